keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 15 +
 rtl/keypad_debounce.sv | 82 ++++++++
 rtl/keypad_scanner.sv | 78 +++++++
 tb/tb_keypad_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, column reset pattern and key indexing.
// Also imported by the game logic that consumes key events.
package keypad_pkg;

  localparam int KP_COLS = 4;
  localparam int KP_ROWS = 4;
  localparam int KP_KEYS = KP_COLS * KP_ROWS;

  localparam logic [KP_COLS-1:0] KP_COL_RESET = 4'b1110;

  function automatic logic [3:0] key_index(input logic [1:0] col, input logic [1:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-stability filter: publishes a key bitmap once DEBOUNCE consecutive frames agree,
// and reports the lowest newly pressed key with a one-cycle pulse.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_fClose,
  input  logic [KP_KEYS-1:0] i_Frame,
  output logic [KP_KEYS-1:0] o_Key_State,
  output logic [3:0]         o_Key_Code,
  output logic               o_fPress
);

  localparam int SW = $clog2(DEBOUNCE);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE - 1);

  logic [KP_KEYS-1:0] prev_q, prev_d;
  logic [KP_KEYS-1:0] state_q, state_d;
  logic [KP_KEYS-1:0] new_press;
  logic [SW-1:0]      stable_q, stable_d, stable_inc;
  logic [3:0]         code_q, code_d, low_idx;
  logic               press_q, press_d;
  logic               same, publish;

  assign same       = (i_Frame == prev_q);
  assign stable_inc = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + 1'b1;
  assign new_press  = i_Frame & ~state_q;
  // A frame that differs from its predecessor can never publish.
  assign publish    = i_fClose && same && (stable_inc == STABLE_MAX) && (i_Frame != state_q);

  always_comb begin
    low_idx = '0;
    for (int c = KP_COLS - 1; c >= 0; c--) begin
      for (int r = KP_ROWS - 1; r >= 0; r--) begin
        if (new_press[key_index(2'(c), 2'(r))]) low_idx = key_index(2'(c), 2'(r));
      end
    end
  end

  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    state_d  = state_q;
    code_d   = code_q;
    press_d  = 1'b0;
    if (i_fClose) begin
      prev_d   = i_Frame;
      stable_d = same ? stable_inc : '0;
    end
    if (publish) begin
      state_d = i_Frame;
      if (|new_press) begin
        code_d  = low_idx;
        press_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      prev_q   <= '0;
      stable_q <= '0;
      state_q  <= '0;
      code_q   <= '0;
      press_q  <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      stable_q <= stable_d;
      state_q  <= state_d;
      code_q   <= code_d;
      press_q  <= press_d;
    end
  end

  assign o_Key_State = state_q;
  assign o_Key_Code  = code_q;
  assign o_fPress    = press_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix scanner: drives one active-low column per period, samples the synchronized
// rows at the end of each period and hands complete frames to the debounce filter.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CNT = 100000,
  parameter int DEBOUNCE = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [KP_ROWS-1:0] i_KP_Row,
  output logic [KP_COLS-1:0] o_KP_Col,
  output logic [KP_KEYS-1:0] o_Key_State,
  output logic [3:0]         o_Key_Code,
  output logic               o_fPress,
  output logic               o_fScanDone
);

  localparam int CW = $clog2(SCAN_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CNT - 1);

  logic [KP_ROWS-1:0] row_meta_q, row_sync_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [KP_COLS-1:0] col_q, col_d;
  logic [KP_KEYS-1:0] raw_q, raw_d, frame;
  logic               f_tick;

  assign f_tick      = (cnt_q == CNT_LAST);
  assign o_fScanDone = f_tick && (col_idx_q == 2'(KP_COLS - 1));

  assign cnt_d     = f_tick ? '0 : cnt_q + 1'b1;
  assign col_d     = f_tick ? {col_q[KP_COLS-2:0], col_q[KP_COLS-1]} : col_q;
  assign col_idx_d = f_tick ? col_idx_q + 2'd1 : col_idx_q;

  // Rows are sampled at the end of the column period so the lines have the whole period to settle.
  generate
    for (genvar gi = 0; gi < KP_COLS; gi++) begin : g_raw
      assign raw_d[gi*KP_ROWS +: KP_ROWS] = (f_tick && (col_idx_q == 2'(gi))) ?
                                            ~row_sync_q : raw_q[gi*KP_ROWS +: KP_ROWS];
    end
  endgenerate

  assign frame = {~row_sync_q, raw_q[KP_KEYS-KP_ROWS-1:0]};

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      cnt_q      <= '0;
      col_idx_q  <= '0;
      col_q      <= KP_COL_RESET;
      raw_q      <= '0;
    end else begin
      row_meta_q <= i_KP_Row;
      row_sync_q <= row_meta_q;
      cnt_q      <= cnt_d;
      col_idx_q  <= col_idx_d;
      col_q      <= col_d;
      raw_q      <= raw_d;
    end
  end

  assign o_KP_Col = col_q;

  keypad_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_fClose    (o_fScanDone),
    .i_Frame     (frame),
    .o_Key_State (o_Key_State),
    .o_Key_Code  (o_Key_Code),
    .o_fPress    (o_fPress)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix row model, frame-history reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized key phase.
module tb_keypad_scanner;

  localparam int SCAN_CNT = 4;
  localparam int DEBOUNCE = 4;
  localparam int FRAME    = 4 * SCAN_CNT;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] state;
  logic [3:0]  code;
  logic        press;
  logic        done;
  logic [15:0] keys = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_CNT(SCAN_CNT),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst_n),
    .i_KP_Row    (row),
    .o_KP_Col    (col),
    .o_Key_State (state),
    .o_Key_Code  (code),
    .o_fPress    (press),
    .o_fScanDone (done)
  );

  // Passive matrix: a row reads low only when a pressed key sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (keys[c*4 + r] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: keys history per clock edge, frames as lists, publish when the
  // last DEBOUNCE frames (reset counts as one all-zero frame) agree and differ from the state.
  int          m;
  logic [15:0] hist [32];
  logic [15:0] prev_f, exp_state, f, newp;
  int          run;
  logic [3:0]  exp_code;
  logic        exp_press;
  int          dut_np, dut_pm;
  logic [3:0]  one = 4'b0001;

  function automatic logic [15:0] model_frame(input int mm);
    logic [15:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      logic [15:0] h;
      h = hist[(mm - 14 + 4*c) % 32];
      for (int k = 0; k < 4; k++) r[c*4 + k] = h[c*4 + k];
    end
    return r;
  endfunction

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m = 0; prev_f = '0; run = 1; exp_state = '0; exp_code = '0; exp_press = 1'b0;
      dut_np = 0; dut_pm = -1;
    end else begin
      m++;
      hist[m % 32] = keys;
      exp_press = 1'b0;
      if (m % FRAME == 0) begin
        f = model_frame(m);
        if (f == prev_f) run++; else run = 1;
        prev_f = f;
        if (run >= DEBOUNCE && f != exp_state) begin
          newp      = f & ~exp_state;
          exp_state = f;
          if (newp != 0) begin
            exp_press = 1'b1;
            exp_code  = lowest(newp);
          end
        end
      end
      if (press) begin
        dut_np++;
        dut_pm = m;
      end
    end
    chk("col",   32'(col),   32'(4'b1111 ^ (one << ((m / SCAN_CNT) % 4))));
    chk("done",  32'(done),  32'((m % FRAME) == FRAME - 1));
    chk("state", 32'(state), 32'(exp_state));
    chk("code",  32'(code),  32'(exp_code));
    chk("press", 32'(press), 32'(exp_press));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] k);
    rst_n = 1'b0;
    keys  = k;
    step(3);
    rst_n = 1'b1;
  endtask

  int bend;

  initial begin
    // 1: idle scan
    do_reset(16'h0000);
    step(80);
    chk("s1_state", 32'(state), 32'h0);
    chk("s1_npress", 32'(dut_np), 32'd0);
    $display("[TB] s1 idle scan: state=%h presses=%0d", state, dut_np);

    // 2: key 9 held clean from reset
    do_reset(16'h0200);
    step(80);
    chk("s2_edge", 32'(dut_pm), 32'd64);
    chk("s2_npress", 32'(dut_np), 32'd1);
    chk("s2_state", 32'(state), 32'h0200);
    chk("s2_code", 32'(code), 32'd9);
    chk("s2_model", 32'(exp_state), 32'h0200);
    step(64);
    chk("s2_norepeat", 32'(dut_np), 32'd1);
    $display("[TB] s2 key9 held: state=%h code=%0d press_edge=%0d", state, code, dut_pm);

    // 3: key 9 bouncing for 5 scans, then held
    do_reset(16'h0000);
    for (int i = 0; i < 8; i++) begin
      keys[9] = ~keys[9];
      step(10);
    end
    chk("s3_bounce_npress", 32'(dut_np), 32'd0);
    chk("s3_bounce_state", 32'(state), 32'h0);
    bend    = m;
    keys[9] = 1'b1;
    step(6 * FRAME);
    chk("s3_npress", 32'(dut_np), 32'd1);
    chk("s3_latency", 32'(dut_pm > bend && dut_pm <= bend + 5 * FRAME), 32'd1);
    chk("s3_state", 32'(state), 32'h0200);
    $display("[TB] s3 bounce: stop_edge=%0d press_edge=%0d", bend, dut_pm);

    // 4: two keys pressed in the same cycle
    do_reset(16'h0000);
    step(37);
    keys = 16'h1008;
    step(6 * FRAME);
    chk("s4_state", 32'(state), 32'h1008);
    chk("s4_code", 32'(code), 32'd3);
    chk("s4_npress", 32'(dut_np), 32'd1);
    $display("[TB] s4 keys 3+12: state=%h code=%0d presses=%0d", state, code, dut_np);

    // 5: press key 0 and release key 9 together
    do_reset(16'h0200);
    step(6 * FRAME);
    chk("s5_state_a", 32'(state), 32'h0200);
    keys = 16'h0001;
    step(6 * FRAME);
    chk("s5_state_b", 32'(state), 32'h0001);
    chk("s5_code", 32'(code), 32'd0);
    chk("s5_npress", 32'(dut_np), 32'd2);
    $display("[TB] s5 swap: state=%h code=%0d presses=%0d", state, code, dut_np);

    // randomized key activity, checked by the per-cycle model
    do_reset(16'h0000);
    for (int i = 0; i < 40; i++) begin
      keys = 16'($urandom) & 16'($urandom) & 16'($urandom);
      step($urandom_range(1, 100));
    end
    $display("[TB] random phase: final state=%h model=%h", state, exp_state);

    // 6: reset mid-scan with a published key
    do_reset(16'h0020);
    step(80);
    chk("s6_pre_state", 32'(state), 32'h0020);
    chk("s6_pre_code", 32'(code), 32'd5);
    step(5);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_col", 32'(col), 32'(4'b1110));
    chk("s6_rst_state", 32'(state), 32'h0);
    chk("s6_rst_code", 32'(code), 32'd0);
    chk("s6_rst_press", 32'(press), 32'd0);
    step(3);
    rst_n = 1'b1;
    step(80);
    chk("s6_edge", 32'(dut_pm), 32'd64);
    chk("s6_state", 32'(state), 32'h0020);
    chk("s6_npress", 32'(dut_np), 32'd1);
    $display("[TB] s6 reset mid-scan: state=%h code=%0d press_edge=%0d", state, code, dut_pm);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
